simmem_release_scheduler: RTL



---
 rtl/simmem_release_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/simmem_release_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : simmem_release_scheduler
//  Purpose  : Tracks delayed transactions in a small slot pool and raises
//             per-ID release enables for the linked-list response bank,
//             keeping per-ID release order equal to acceptance order.
//  Revision : 1.0 - initial release
// ============================================================================
module simmem_release_scheduler #(
    parameter int IDWidth    = 8,
    parameter int NumSlots   = 16,
    parameter int DelayWidth = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [IDWidth-1:0]               req_id_i,
    input  logic [DelayWidth-1:0]            req_delay_i,
    output logic [2**IDWidth-1:0]            release_en_o,
    input  logic                             release_ack_i,
    input  logic [IDWidth-1:0]               release_ack_id_i,
    output logic [$clog2(NumSlots+1)-1:0]    occupancy_o,
    output logic                             err_o
);

    localparam int OccWidth = $clog2(NumSlots + 1);

    // Per-slot state. older_q[s][j] set means slot j holds the same ID,
    // was accepted before slot s and is still outstanding.
    logic [NumSlots-1:0]   valid_q, valid_d;
    logic [IDWidth-1:0]    id_q    [NumSlots];
    logic [IDWidth-1:0]    id_d    [NumSlots];
    logic [DelayWidth-1:0] cnt_q   [NumSlots];
    logic [DelayWidth-1:0] cnt_d   [NumSlots];
    logic [NumSlots-1:0]   older_q [NumSlots];
    logic [NumSlots-1:0]   older_d [NumSlots];
    logic [OccWidth-1:0]   occ_q, occ_d;
    logic                  err_q, err_d;

    logic [NumSlots-1:0]   eligible;
    logic [NumSlots-1:0]   free_vec;
    logic                  free_hit;
    logic [NumSlots-1:0]   alloc_vec;
    logic                  alloc_found;
    logic [NumSlots-1:0]   same_id;
    logic [NumSlots-1:0]   new_older;
    logic                  accept;

    // Ready depends on registered state only; a slot being freed this cycle
    // is still valid here, so it can never be re-allocated in the same cycle.
    assign req_ready_o = |(~valid_q);
    assign accept      = req_valid_i && req_ready_o;
    assign occupancy_o = occ_q;
    assign err_o       = err_q;

    // Eligibility, release enables and selection of the slot to free.
    always_comb begin
        eligible     = '0;
        free_vec     = '0;
        free_hit     = 1'b0;
        release_en_o = '0;
        for (int s = 0; s < NumSlots; s++) begin
            eligible[s] = valid_q[s] && (older_q[s] == '0) && (cnt_q[s] == '0);
            if (eligible[s]) begin
                release_en_o[id_q[s]] = 1'b1;
            end
            // At most one eligible slot per ID exists (only the head can be
            // eligible); the priority guard just keeps free_vec one-hot.
            if (release_ack_i && eligible[s] && (id_q[s] == release_ack_id_i)
                && !free_hit) begin
                free_vec[s] = 1'b1;
                free_hit    = 1'b1;
            end
        end
    end

    // Lowest-index free slot allocation and the new slot's age mask.
    always_comb begin
        alloc_vec   = '0;
        alloc_found = 1'b0;
        same_id     = '0;
        for (int s = 0; s < NumSlots; s++) begin
            if (!valid_q[s] && !alloc_found) begin
                alloc_vec[s] = req_valid_i;
                alloc_found  = 1'b1;
            end
            same_id[s] = valid_q[s] && (id_q[s] == req_id_i);
        end
        // A same-ID slot released this cycle must not block the new one.
        new_older = same_id & ~free_vec;
    end

    // Next-state for slots, occupancy and the sticky error flag.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        older_d = older_q;
        for (int s = 0; s < NumSlots; s++) begin
            if (alloc_vec[s]) begin
                valid_d[s] = 1'b1;
                id_d[s]    = req_id_i;
                cnt_d[s]   = req_delay_i;
                older_d[s] = new_older;
            end else if (free_vec[s]) begin
                valid_d[s] = 1'b0;
                older_d[s] = '0;
            end else if (valid_q[s]) begin
                if (cnt_q[s] != '0) begin
                    cnt_d[s] = cnt_q[s] - DelayWidth'(1);
                end
                older_d[s] = older_q[s] & ~free_vec;
            end
        end

        case ({accept, free_hit})
            2'b10:   occ_d = occ_q + OccWidth'(1);
            2'b01:   occ_d = occ_q - OccWidth'(1);
            default: occ_d = occ_q;
        endcase

        err_d = err_q | (release_ack_i && !free_hit);
    end

    // State registers with synchronous reset discarding all pending slots.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
            for (int s = 0; s < NumSlots; s++) begin
                id_q[s]    <= '0;
                cnt_q[s]   <= '0;
                older_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
            for (int s = 0; s < NumSlots; s++) begin
                id_q[s]    <= id_d[s];
                cnt_q[s]   <= cnt_d[s];
                older_q[s] <= older_d[s];
            end
        end
    end

endmodule
`default_nettype wire
